// File: rtl/qos_class_router.sv
// QoS class router: one input FIFO steered by a class field into NUM_CH class FIFOs,
// threshold-based back-pressure, init/idle/active/error FSM and per-class pop counters.
module qos_class_router #(
  parameter int DATA_W  = 12,
  parameter int NUM_CH  = 4,
  parameter int CH_W    = 2,
  parameter int SEL_LSB = 8,
  parameter int DEPTH   = 8,
  parameter int PTR_W   = 3,
  parameter int CNT_W   = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     init,
  input  logic [PTR_W:0]           umbral_high,
  input  logic [PTR_W:0]           umbral_low,
  input  logic                     push,
  input  logic [DATA_W-1:0]        data_in,
  input  logic [NUM_CH-1:0]        pop,
  output logic [NUM_CH*DATA_W-1:0] data_out,
  output logic [NUM_CH-1:0]        valid_out,
  output logic [NUM_CH-1:0]        empty,
  output logic [NUM_CH-1:0]        almost_full,
  output logic [NUM_CH-1:0]        almost_empty,
  output logic                     in_full,
  input  logic                     req,
  input  logic [CH_W:0]            idx,
  output logic                     valid,
  output logic [CNT_W-1:0]         data,
  output logic                     idle_out,
  output logic                     active_out,
  output logic                     error_out
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] HIGH_RST = (PTR_W+1)'(DEPTH-1);
  localparam logic [PTR_W:0] LOW_RST  = (PTR_W+1)'(1);
  localparam logic [CH_W:0]  IDX_TOT  = (CH_W+1)'(NUM_CH);

  typedef enum logic [2:0] {S_RESET, S_INIT, S_IDLE, S_ACTIVE, S_ERROR} state_t;
  state_t state, state_nx;

  logic [DATA_W-1:0] in_mem [DEPTH];
  logic [PTR_W-1:0]  in_wr, in_rd;
  logic [PTR_W:0]    in_cnt;

  logic [DATA_W-1:0] cls_mem [NUM_CH][DEPTH];
  logic [PTR_W-1:0]  cls_wr  [NUM_CH];
  logic [PTR_W-1:0]  cls_rd  [NUM_CH];
  logic [PTR_W:0]    cls_cnt [NUM_CH];

  logic [PTR_W:0]    thr_high, thr_low;
  logic [CNT_W-1:0]  cnt [NUM_CH];
  logic [CNT_W-1:0]  total, pop_sum;

  logic [CH_W-1:0]   head_cls;
  logic [NUM_CH-1:0] pop_ok, cls_wen;
  logic              in_empty, xfer, accepting, push_ok, overflow, busy;

  // Handshakes: a word enters on push when in_full=0 (or the head leaves the same cycle);
  // a class word leaves on pop[c] when empty[c]=0. Requests against a blocked side are dropped.
  assign head_cls  = in_mem[in_rd][SEL_LSB +: CH_W];
  assign in_empty  = (in_cnt == '0);
  assign in_full   = (in_cnt == FULL_CNT);
  assign xfer      = !in_empty && !almost_full[head_cls] && (cls_cnt[head_cls] != FULL_CNT);
  assign accepting = (state == S_IDLE) || (state == S_ACTIVE);
  assign push_ok   = push && accepting && (!in_full || xfer);
  assign overflow  = push && in_full && !xfer && (state != S_RESET);
  assign busy      = !in_empty || !(&empty);

  always_comb begin
    pop_sum = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      empty[c]        = (cls_cnt[c] == '0);
      almost_full[c]  = (cls_cnt[c] >= thr_high);
      almost_empty[c] = (cls_cnt[c] <= thr_low);
      pop_ok[c]       = pop[c] && (cls_cnt[c] != '0);
      cls_wen[c]      = xfer && (head_cls == CH_W'(c));
      pop_sum         = pop_sum + CNT_W'(pop_ok[c]);
    end
  end

  // Storage arrays carry no reset; pointers and counts define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) in_mem[in_wr] <= data_in;
    for (int c = 0; c < NUM_CH; c++)
      if (cls_wen[c]) cls_mem[c][cls_wr[c]] <= in_mem[in_rd];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_wr  <= '0;
      in_rd  <= '0;
      in_cnt <= '0;
    end else begin
      if (push_ok) in_wr <= in_wr + 1'b1;
      if (xfer)    in_rd <= in_rd + 1'b1;
      case ({push_ok, xfer})
        2'b10:   in_cnt <= in_cnt + 1'b1;
        2'b01:   in_cnt <= in_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        cls_wr[c]  <= '0;
        cls_rd[c]  <= '0;
        cls_cnt[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (cls_wen[c]) cls_wr[c] <= cls_wr[c] + 1'b1;
        if (pop_ok[c])  cls_rd[c] <= cls_rd[c] + 1'b1;
        case ({cls_wen[c], pop_ok[c]})
          2'b10:   cls_cnt[c] <= cls_cnt[c] + 1'b1;
          2'b01:   cls_cnt[c] <= cls_cnt[c] - 1'b1;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out  <= '0;
      valid_out <= '0;
      total     <= '0;
      valid     <= 1'b0;
      data      <= '0;
      for (int c = 0; c < NUM_CH; c++) cnt[c] <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        valid_out[c] <= pop_ok[c];
        if (pop_ok[c]) begin
          data_out[c*DATA_W +: DATA_W] <= cls_mem[c][cls_rd[c]];
          cnt[c]                       <= cnt[c] + 1'b1;
        end
      end
      total <= total + pop_sum;
      valid <= req;
      if (!req)                data <= '0;
      else if (idx < IDX_TOT)  data <= cnt[idx[CH_W-1:0]];
      else if (idx == IDX_TOT) data <= total;
      else                     data <= '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      thr_high <= HIGH_RST;
      thr_low  <= LOW_RST;
    end else if (state == S_INIT) begin
      thr_high <= umbral_high;
      thr_low  <= umbral_low;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_RESET;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_RESET:  state_nx = S_INIT;
      S_INIT:   if (overflow) state_nx = S_ERROR;
                else if (!init) state_nx = S_IDLE;
      S_IDLE:   if (overflow) state_nx = S_ERROR;
                else if (init) state_nx = S_INIT;
                else if (busy) state_nx = S_ACTIVE;
      S_ACTIVE: if (overflow) state_nx = S_ERROR;
                else if (init) state_nx = S_INIT;
                else if (!busy) state_nx = S_IDLE;
      S_ERROR:  state_nx = S_ERROR;
      default:  state_nx = S_RESET;
    endcase
  end

  assign idle_out   = (state == S_IDLE);
  assign active_out = (state == S_ACTIVE);
  assign error_out  = (state == S_ERROR);

endmodule

// File: tb/tb_qos_class_router.sv
// Bench for qos_class_router: hand vector table, directed corner sequences and random
// traffic, all checked against a queue-based reference model of the router.
module tb_qos_class_router;

  localparam int DATA_W  = 12;
  localparam int NUM_CH  = 4;
  localparam int CH_W    = 2;
  localparam int SEL_LSB = 8;
  localparam int DEPTH   = 8;
  localparam int PTR_W   = 3;
  localparam int CNT_W   = 8;

  localparam int M_RESET = 0, M_INIT = 1, M_IDLE = 2, M_ACTIVE = 3, M_ERROR = 4;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     init;
  logic [PTR_W:0]           umbral_high, umbral_low;
  logic                     push;
  logic [DATA_W-1:0]        data_in;
  logic [NUM_CH-1:0]        pop;
  logic [NUM_CH*DATA_W-1:0] data_out;
  logic [NUM_CH-1:0]        valid_out, empty, almost_full, almost_empty;
  logic                     in_full;
  logic                     req;
  logic [CH_W:0]            idx;
  logic                     valid;
  logic [CNT_W-1:0]         data;
  logic                     idle_out, active_out, error_out;

  qos_class_router #(
    .DATA_W(DATA_W), .NUM_CH(NUM_CH), .CH_W(CH_W), .SEL_LSB(SEL_LSB),
    .DEPTH(DEPTH), .PTR_W(PTR_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .init(init),
    .umbral_high(umbral_high), .umbral_low(umbral_low),
    .push(push), .data_in(data_in), .pop(pop),
    .data_out(data_out), .valid_out(valid_out), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .in_full(in_full),
    .req(req), .idx(idx), .valid(valid), .data(data),
    .idle_out(idle_out), .active_out(active_out), .error_out(error_out)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- reference model ----------------
  logic [DATA_W-1:0] in_q[$];
  logic [DATA_W-1:0] exp_q[NUM_CH][$];
  int                m_state, m_hi, m_lo, m_tot, m_data;
  int                m_cnt[NUM_CH];
  logic [DATA_W-1:0] m_dout[NUM_CH];
  logic [NUM_CH-1:0] m_vout;
  logic              m_valid;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit m_xfer();
    logic [DATA_W-1:0] h;
    int hc;
    if (in_q.size() == 0) return 1'b0;
    h  = in_q[0];
    hc = int'(h[SEL_LSB +: CH_W]);
    return (exp_q[hc].size() < m_hi) && (exp_q[hc].size() < DEPTH);
  endfunction

  task automatic model_reset();
    in_q.delete();
    for (int c = 0; c < NUM_CH; c++) begin
      exp_q[c].delete();
      m_cnt[c]  = 0;
      m_dout[c] = '0;
    end
    m_state = M_RESET;
    m_hi = DEPTH - 1;
    m_lo = 1;
    m_tot = 0;
    m_vout = '0;
    m_valid = 1'b0;
    m_data = 0;
  endtask

  task automatic model_step();
    bit full, xf, busy, push_ok, ovf;
    logic [DATA_W-1:0] h;
    int hc;
    int lim;
    lim  = 1 << CNT_W;
    full = (in_q.size() == DEPTH);
    xf   = m_xfer();
    busy = (in_q.size() != 0);
    for (int c = 0; c < NUM_CH; c++) if (exp_q[c].size() != 0) busy = 1'b1;
    push_ok = push && (m_state == M_IDLE || m_state == M_ACTIVE) && (!full || xf);
    ovf     = push && full && !xf && (m_state != M_RESET);
    m_valid = req;
    if (!req)               m_data = 0;
    else if (idx < NUM_CH)  m_data = m_cnt[idx];
    else if (idx == NUM_CH) m_data = m_tot;
    else                    m_data = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (pop[c] && exp_q[c].size() > 0) begin
        m_dout[c] = exp_q[c].pop_front();
        m_vout[c] = 1'b1;
        m_cnt[c]  = (m_cnt[c] + 1) % lim;
        m_tot     = (m_tot + 1) % lim;
      end else begin
        m_vout[c] = 1'b0;
      end
    end
    if (xf) begin
      h  = in_q.pop_front();
      hc = int'(h[SEL_LSB +: CH_W]);
      exp_q[hc].push_back(h);
    end
    if (push_ok) in_q.push_back(data_in);
    if (m_state == M_INIT) begin
      m_hi = int'(umbral_high);
      m_lo = int'(umbral_low);
    end
    case (m_state)
      M_RESET: m_state = M_INIT;
      M_INIT:  if (ovf) m_state = M_ERROR; else if (!init) m_state = M_IDLE;
      M_IDLE, M_ACTIVE:
        if (ovf) m_state = M_ERROR;
        else if (init) m_state = M_INIT;
        else m_state = busy ? M_ACTIVE : M_IDLE;
      default: ;
    endcase
  endtask

  task automatic compare_all();
    logic [NUM_CH*DATA_W-1:0] ed;
    logic [NUM_CH-1:0] ee, eaf, eae;
    for (int c = 0; c < NUM_CH; c++) begin
      ed[c*DATA_W +: DATA_W] = m_dout[c];
      ee[c]  = (exp_q[c].size() == 0);
      eaf[c] = (exp_q[c].size() >= m_hi);
      eae[c] = (exp_q[c].size() <= m_lo);
    end
    check("data_out",     128'(data_out),     128'(ed));
    check("valid_out",    128'(valid_out),    128'(m_vout));
    check("empty",        128'(empty),        128'(ee));
    check("almost_full",  128'(almost_full),  128'(eaf));
    check("almost_empty", 128'(almost_empty), 128'(eae));
    check("in_full",      128'(in_full),      128'(in_q.size() == DEPTH));
    check("valid",        128'(valid),        128'(m_valid));
    check("data",         128'(data),         128'(m_data));
    check("idle_out",     128'(idle_out),     128'(m_state == M_IDLE));
    check("active_out",   128'(active_out),   128'(m_state == M_ACTIVE));
    check("error_out",    128'(error_out),    128'(m_state == M_ERROR));
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic drive(input int i_init, input int hi, input int lo, input int i_push,
                       input int din, input int i_pop, input int i_req, input int i_idx);
    init        = (i_init != 0);
    umbral_high = (PTR_W+1)'(hi);
    umbral_low  = (PTR_W+1)'(lo);
    push        = (i_push != 0);
    data_in     = DATA_W'(din);
    pop         = NUM_CH'(i_pop);
    req         = (i_req != 0);
    idx         = (CH_W+1)'(i_idx);
    cycle();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " data_out"},   128'(data_out),   128'(0));
    check({tag, " valid_out"},  128'(valid_out),  128'(0));
    check({tag, " valid"},      128'(valid),      128'(0));
    check({tag, " data"},       128'(data),       128'(0));
    check({tag, " empty"},      128'(empty),      128'({NUM_CH{1'b1}}));
    check({tag, " in_full"},    128'(in_full),    128'(0));
    check({tag, " idle_out"},   128'(idle_out),   128'(0));
    check({tag, " active_out"}, 128'(active_out), 128'(0));
    check({tag, " error_out"},  128'(error_out),  128'(0));
  endtask

  // Asserts reset between edges, checks outputs immediately, then releases after one edge.
  task automatic async_reset(input string tag);
    #2 reset = 1'b1;
    #1 check_reset_values(tag);
    model_reset();
    @(posedge clk);
    #1 compare_all();
    init = 1'b0; push = 1'b0; pop = '0; req = 1'b0; idx = '0;
    reset = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic              init;
    logic [PTR_W:0]    hi, lo;
    logic              push;
    logic [DATA_W-1:0] din;
    logic [NUM_CH-1:0] pop;
    logic [NUM_CH-1:0] e_empty, e_af, e_vout;
    logic              e_idle, e_active;
  } vec_t;

  function automatic vec_t mk(input int i_init, input int hi, input int lo, input int i_push,
                              input int din, input int i_pop, input int e_empty,
                              input int e_af, input int e_vout, input int e_idle,
                              input int e_active);
    vec_t v;
    v.init = (i_init != 0);     v.hi = (PTR_W+1)'(hi);       v.lo = (PTR_W+1)'(lo);
    v.push = (i_push != 0);     v.din = DATA_W'(din);        v.pop = NUM_CH'(i_pop);
    v.e_empty = NUM_CH'(e_empty); v.e_af = NUM_CH'(e_af);    v.e_vout = NUM_CH'(e_vout);
    v.e_idle = (e_idle != 0);   v.e_active = (e_active != 0);
    return v;
  endfunction

  vec_t vecs[20];
  logic [DATA_W-1:0] t4_c0[4];
  logic [DATA_W-1:0] t4_c1[4];

  initial begin
    // init with (7,2) then (5,1), then leave INIT; 8 words to classes 0 and 1;
    // fill class 0 to the threshold, block the head, release with one pop.
    vecs[0]  = mk(1, 7, 2, 0, 'h000, 0, 'hF, 0, 0, 0, 0);
    vecs[1]  = mk(1, 7, 2, 0, 'h000, 0, 'hF, 0, 0, 0, 0);
    vecs[2]  = mk(1, 5, 1, 0, 'h000, 0, 'hF, 0, 0, 0, 0);
    vecs[3]  = mk(0, 5, 1, 0, 'h000, 0, 'hF, 0, 0, 1, 0);
    vecs[4]  = mk(0, 5, 1, 1, 'h0FF, 0, 'hF, 0, 0, 1, 0);
    vecs[5]  = mk(0, 5, 1, 1, 'h404, 0, 'hE, 0, 0, 0, 1);
    vecs[6]  = mk(0, 5, 1, 1, 'h895, 0, 'hE, 0, 0, 0, 1);
    vecs[7]  = mk(0, 5, 1, 1, 'hCAE, 0, 'hE, 0, 0, 0, 1);
    vecs[8]  = mk(0, 5, 1, 1, 'h15A, 0, 'hE, 0, 0, 0, 1);
    vecs[9]  = mk(0, 5, 1, 1, 'h55A, 0, 'hC, 0, 0, 0, 1);
    vecs[10] = mk(0, 5, 1, 1, 'h95A, 0, 'hC, 0, 0, 0, 1);
    vecs[11] = mk(0, 5, 1, 1, 'hD5A, 0, 'hC, 0, 0, 0, 1);
    vecs[12] = mk(0, 5, 1, 0, 'h000, 0, 'hC, 0, 0, 0, 1);
    vecs[13] = mk(0, 5, 1, 1, 'h001, 0, 'hC, 0, 0, 0, 1);
    vecs[14] = mk(0, 5, 1, 1, 'h002, 0, 'hC, 1, 0, 0, 1);
    vecs[15] = mk(0, 5, 1, 1, 'h103, 0, 'hC, 1, 0, 0, 1);
    vecs[16] = mk(0, 5, 1, 0, 'h000, 0, 'hC, 1, 0, 0, 1);
    vecs[17] = mk(0, 5, 1, 0, 'h000, 1, 'hC, 0, 1, 0, 1);
    vecs[18] = mk(0, 5, 1, 0, 'h000, 0, 'hC, 1, 0, 0, 1);
    vecs[19] = mk(0, 5, 1, 0, 'h000, 0, 'hC, 3, 0, 0, 1);
    t4_c0[0] = 12'h404; t4_c0[1] = 12'h895; t4_c0[2] = 12'hCAE; t4_c0[3] = 12'h001;
    t4_c1[0] = 12'h15A; t4_c1[1] = 12'h55A; t4_c1[2] = 12'h95A; t4_c1[3] = 12'hD5A;

    // ---------------- reset ----------------
    reset = 1'b1; init = 1'b0; umbral_high = '0; umbral_low = '0;
    push = 1'b0; data_in = '0; pop = '0; req = 1'b0; idx = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    compare_all();
    reset = 1'b0;

    // ---------------- table ----------------
    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].init, vecs[i].hi, vecs[i].lo, vecs[i].push, vecs[i].din,
            vecs[i].pop, 0, 0);
      check($sformatf("vec%0d empty", i),       128'(empty),       128'(vecs[i].e_empty));
      check($sformatf("vec%0d almost_full", i), 128'(almost_full), 128'(vecs[i].e_af));
      check($sformatf("vec%0d valid_out", i),   128'(valid_out),   128'(vecs[i].e_vout));
      check($sformatf("vec%0d idle_out", i),    128'(idle_out),    128'(vecs[i].e_idle));
      check($sformatf("vec%0d active_out", i),  128'(active_out),  128'(vecs[i].e_active));
    end

    // ---------------- pop all classes, then counter readback ----------------
    for (int k = 0; k < 4; k++) begin
      drive(0, 5, 1, 0, 0, 'hF, 0, 0);
      check($sformatf("pop%0d valid_out", k), 128'(valid_out), 128'(4'b0011));
      check($sformatf("pop%0d class0", k), 128'(data_out[0 +: DATA_W]), 128'(t4_c0[k]));
      check($sformatf("pop%0d class1", k), 128'(data_out[DATA_W +: DATA_W]), 128'(t4_c1[k]));
    end
    drive(0, 5, 1, 0, 0, 0, 1, 4);
    check("total count", 128'(data), 128'(9));
    check("total valid", 128'(valid), 128'(1));
    drive(0, 5, 1, 0, 0, 0, 1, 0);
    check("class0 count", 128'(data), 128'(5));
    drive(0, 5, 1, 0, 0, 0, 1, 1);
    check("class1 count", 128'(data), 128'(4));
    drive(0, 5, 1, 0, 0, 0, 1, 6);
    check("idx out of range data", 128'(data), 128'(0));
    check("idx out of range valid", 128'(valid), 128'(1));
    drive(0, 5, 1, 0, 0, 0, 0, 4);
    check("no req valid", 128'(valid), 128'(0));

    // ---------------- random traffic ----------------
    for (int i = 0; i < 600; i++) begin
      if (i % 150 == 75) begin
        int hi, lo;
        hi = $urandom_range(1, DEPTH);
        lo = $urandom_range(0, 3);
        drive(1, hi, lo, 0, 0, 0, 0, 0);
        drive(1, hi, lo, 0, 0, 0, 0, 0);
        drive(0, hi, lo, 0, 0, 0, 0, 0);
      end else begin
        bit fill;
        fill = ((i / 150) % 2) == 0;
        init    = 1'b0;
        push    = fill ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 3);
        if (push && in_q.size() == DEPTH && !m_xfer()) push = 1'b0;
        data_in = DATA_W'($urandom);
        pop     = fill ? NUM_CH'($urandom & $urandom) : NUM_CH'($urandom | $urandom);
        req     = $urandom_range(0, 1) == 1;
        idx     = (CH_W+1)'($urandom_range(0, 7));
        cycle();
      end
    end

    // ---------------- overflow into ERROR ----------------
    drive(1, 0, 1, 0, 0, 0, 0, 0);
    drive(1, 0, 1, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < DEPTH + 1; k++)
      if (in_q.size() < DEPTH) drive(0, 0, 1, 1, int'($urandom_range(0, 4095)), 0, 0, 0);
    check("fill in_full", 128'(in_full), 128'(1));
    drive(0, 0, 1, 1, 'hABC, 0, 0, 0);
    check("overflow error_out", 128'(error_out), 128'(1));
    check("overflow active_out", 128'(active_out), 128'(0));
    drive(1, 0, 1, 0, 0, 'hF, 0, 0);
    check("error sticky", 128'(error_out), 128'(1));

    // ---------------- resets, including mid-burst ----------------
    async_reset("err reset");
    drive(1, 5, 1, 0, 0, 0, 0, 0);
    drive(1, 5, 1, 0, 0, 0, 0, 0);
    drive(0, 5, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++)
      drive(0, 5, 1, 1, int'($urandom_range(0, 4095)), 'hF, 1, 4);
    push = 1'b1; pop = '1; req = 1'b1;
    async_reset("mid reset");
    for (int k = 0; k < 4; k++)
      drive(0, 5, 1, k % 2, int'($urandom_range(0, 4095)), 'hF, 1, k);
    check("post reset idle_out", 128'(idle_out), 128'(1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
